column_approx_div: RTL and testbench

- Sequential restoring divider: the inverse operation of the column-truncated approximate multipliers.
- Divides a 2*LENGTH-bit dividend (a product) by a LENGTH-bit divisor and returns a LENGTH-bit quotient and remainder.
- Approximation mirrors the multiplier: the low THETA columns of the dividend are zeroed before division.
- Used in the PPCT error-characterisation path to recover operands from approximate products. Fixed latency, start/done handshake.

---
 rtl/column_approx_div.sv | 142 ++++++++++++++
 tb/tb_column_approx_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/column_approx_div.sv
// Multi-cycle restoring divider. Before dividing, it zeroes the low THETA columns of the dividend,
// so it is the inverse of the column-truncated approximate multiplier.
module column_approx_div #(
    parameter int LENGTH = 8,
    parameter int THETA  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*LENGTH-1:0]   dividend,
    input  logic [LENGTH-1:0]     divisor,
    output logic                  busy,
    output logic                  done,
    output logic [LENGTH-1:0]     q,
    output logic [LENGTH-1:0]     r,
    output logic                  ovf,
    output logic                  dz
);
    localparam int DW = 2 * LENGTH;
    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
    localparam logic [DW-1:0] TRUNC_MASK = {DW{1'b1}} << THETA;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LENGTH-1:0] rem_q, rem_d;
    logic [LENGTH-1:0] low_q, low_d;
    logic [LENGTH-1:0] quo_q, quo_d;
    logic [LENGTH-1:0] div_q, div_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              dz_pend_q, dz_pend_d;
    logic              done_q, done_d;
    logic [LENGTH-1:0] q_q, q_d;
    logic [LENGTH-1:0] r_q, r_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;

    logic [DW-1:0]     dt;
    logic [LENGTH:0]   shifted;
    logic              fits;

    assign dt      = dividend & TRUNC_MASK;
    assign shifted = {rem_q, low_q[LENGTH-1]};
    assign fits    = shifted >= {1'b0, div_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        low_d      = low_q;
        quo_d      = quo_q;
        div_d      = div_q;
        ovf_pend_d = ovf_pend_q;
        dz_pend_d  = dz_pend_q;
        done_d     = 1'b0;
        q_d        = q_q;
        r_d        = r_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d      = dt[DW-1:LENGTH];
                    low_d      = dt[LENGTH-1:0];
                    div_d      = divisor;
                    quo_d      = '0;
                    cnt_d      = '0;
                    dz_pend_d  = (divisor == '0);
                    ovf_pend_d = (divisor != '0) && (dt[DW-1:LENGTH] >= divisor);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // Once the remainder has been reduced it is below the divisor, so the difference fits in LENGTH bits.
                rem_d = fits ? LENGTH'(shifted - {1'b0, div_q}) : shifted[LENGTH-1:0];
                low_d = low_q << 1;
                quo_d = (quo_q << 1) | LENGTH'(fits);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                ovf_d  = ovf_pend_q;
                dz_d   = dz_pend_q;
                if (ovf_pend_q || dz_pend_q) begin
                    q_d = '1;
                    r_d = '0;
                end else begin
                    q_d = quo_q;
                    r_d = rem_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            low_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            ovf_pend_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            low_q      <= low_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            ovf_pend_q <= ovf_pend_d;
            dz_pend_q  <= dz_pend_d;
            done_q     <= done_d;
            q_q        <= q_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_column_approx_div.sv
// Scoreboard bench for column_approx_div: expected results are queued when start is driven and
// checked when done pulses.
module tb_column_approx_div;
    localparam int L  = 8;
    localparam int TH = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*L-1:0] dividend;
    logic [L-1:0]   divisor;
    logic           busy, done, ovf, dz;
    logic [L-1:0]   q, r;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic [L-1:0] q;
        logic [L-1:0] r;
        logic         ovf;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    column_approx_div #(.LENGTH(L), .THETA(TH)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .q(q), .r(r), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    function automatic exp_t model(input logic [2*L-1:0] dvd, input logic [L-1:0] dvs);
        exp_t e;
        logic [2*L-1:0] dt;
        dt = (dvd >> TH) << TH;
        e.cyc = 0;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (dvs == 0) begin
            e.dz = 1'b1;
            e.q  = '1;
            e.r  = '0;
        end else if (dt[2*L-1:L] >= dvs) begin
            e.ovf = 1'b1;
            e.q   = '1;
            e.r   = '0;
        end else begin
            e.q = L'(dt / {8'd0, dvs});
            e.r = L'(dt % {8'd0, dvs});
        end
        return e;
    endfunction

    // Call at a negedge; returns at the negedge of the first RUN cycle.
    task automatic issue(input logic [2*L-1:0] dvd, input logic [L-1:0] dvs);
        exp_t e;
        e = model(dvd, dvs);
        e.cyc = cyc_cnt + 1;
        sb.push_back(e);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check("timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q",   32'(q),   32'(e.q));
                check("r",   32'(r),   32'(e.r));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("dz",  32'(dz),  32'(e.dz));
                check("lat", 32'(cyc_cnt - e.cyc), 32'd9);
            end
        end
    end

    initial begin
        exp_t dropped;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    32'(q),    32'd0);
        check("rst_r",    32'(r),    32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_dz",   32'(dz),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 8'h56);
        check("busy_run", 32'(busy), 32'd1);
        wait_done();
        check("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        issue(16'h0FC0, 8'h40); wait_done(); @(negedge clk);
        issue(16'h8000, 8'h10); wait_done(); @(negedge clk);
        issue(16'h1234, 8'h00); wait_done(); @(negedge clk);

        // A start during RUN must be dropped; the monitor flags any extra done.
        issue(16'h2A40, 8'h77);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 16'h0100; divisor = 8'h03;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);

        // Back-to-back: the second start is driven in the done cycle.
        issue(16'h3F00, 8'h41); wait_done();
        issue(16'h00C0, 8'h01); wait_done(); @(negedge clk);

        // Reset in the 4th RUN cycle abandons the operation.
        issue(16'h8000, 8'h10); wait_done(); @(negedge clk);
        issue(16'h1234, 8'h56);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dropped = sb.pop_back();
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q",    32'(q),    32'd0);
        check("mid_rst_r",    32'(r),    32'd0);
        check("mid_rst_ovf",  32'(ovf),  32'd0);
        check("mid_rst_dz",   32'(dz),   32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        for (int i = 0; i < 2000; i++) begin
            logic [L-1:0]   dvs;
            logic [2*L-1:0] dvd;
            case ($urandom_range(0, 7))
                0:       dvs = 8'h00;
                1:       dvs = 8'h01;
                default: dvs = L'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 3) == 0)
                dvd = 16'($urandom_range(0, 16'hFFFF));
            else
                dvd = {L'($urandom_range(0, (dvs == 0) ? 0 : int'(dvs) - 1)), L'($urandom_range(0, 255))};
            issue(dvd, dvs);
            wait_done();
        end
        repeat (3) @(negedge clk);

        check("sb_left", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
